// File: rtl/tmnt_io_frontend_if.sv
// Pin-side and core-side signal bundle of the TMNT GPIO front end.
// The slave modport is the front end; master is the core/pad environment.
interface tmnt_io_frontend_if #(
  parameter int NUM_GPIO  = 34,
  parameter int IN_WIDTH  = 15,
  parameter int OUT_WIDTH = 3
);
  logic                 ncs;
  logic [NUM_GPIO-1:0]  gpio_in;
  logic [NUM_GPIO-1:0]  gpio_out;
  logic [NUM_GPIO-1:0]  gpio_oeb;
  logic [OUT_WIDTH-1:0] core_out;
  logic [IN_WIDTH-1:0]  pb_level;
  logic [IN_WIDTH-1:0]  pb_rise;
  logic                 core_en;

  modport master (
    output ncs, gpio_in, core_out,
    input  gpio_out, gpio_oeb, pb_level, pb_rise, core_en
  );

  modport slave (
    input  ncs, gpio_in, core_out,
    output gpio_out, gpio_oeb, pb_level, pb_rise, core_en
  );
endinterface

// File: rtl/tmnt_io_frontend.sv
// GPIO front end: sync + debounce + press pulse per input pin, registered core outputs (1 cycle).
// Input latency SYNC_STAGES+DEBOUNCE_CYCLES, no backpressure; TMNT_AUTOREPEAT_EN adds held-button repeats.
module tmnt_io_frontend #(
  parameter int NUM_GPIO        = 34,
  parameter int IN_WIDTH        = 15,
  parameter int IN_BASE         = 0,
  parameter int OUT_WIDTH       = 3,
  parameter int OUT_BASE        = 15,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input logic               clk,
  input logic               n_rst,
  tmnt_io_frontend_if.slave io
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync_q, sync_d;
  logic [IN_WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]                  level_q, level_d;
  logic [IN_WIDTH-1:0]                  rise_q, rise_d;
  logic [IN_WIDTH-1:0]                  rep_hit;
  logic [OUT_WIDTH-1:0]                 out_q;
  logic                                 en_q;
  logic [IN_WIDTH-1:0]                  pin_in;
  logic [IN_WIDTH-1:0]                  s;
  logic                                 clr;
  logic                                 unused_gpio_in;

  assign clr            = ~n_rst | io.ncs;
  assign pin_in         = io.gpio_in[IN_BASE +: IN_WIDTH];
  assign s              = sync_q[SYNC_STAGES-1];
  assign unused_gpio_in = ^io.gpio_in;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin_in};
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

`ifdef TMNT_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int PW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

  logic [IN_WIDTH-1:0][HW-1:0] hold_q, hold_d;
  logic [IN_WIDTH-1:0][PW-1:0] per_q, per_d;

  // hold saturates at REPEAT_DELAY; from then on the period counter paces the repeats
  always_comb begin
    hold_d  = '0;
    per_d   = '0;
    rep_hit = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (level_d[i] && level_q[i]) begin
        if (hold_q[i] != HW'(REPEAT_DELAY)) begin
          hold_d[i]  = hold_q[i] + HW'(1);
          rep_hit[i] = (hold_q[i] == HW'(REPEAT_DELAY - 1));
        end else begin
          hold_d[i]  = hold_q[i];
          rep_hit[i] = (per_q[i] == PW'(REPEAT_PERIOD - 1));
          per_d[i]   = rep_hit[i] ? '0 : per_q[i] + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hold_q <= '0;
      per_q  <= '0;
    end else begin
      hold_q <= hold_d;
      per_q  <= per_d;
    end
  end
`else
  assign rep_hit = '0;
`endif

  assign rise_d = level_d & (~level_q | rep_hit);

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      out_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      out_q   <= io.core_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= ~io.ncs;
    end
  end

  // Only the output window is ever driven; every other pin stays a floating input.
  always_comb begin
    io.gpio_out = '0;
    io.gpio_oeb = '1;
    for (int j = 0; j < OUT_WIDTH; j++) begin
      io.gpio_out[OUT_BASE + j] = out_q[j];
      io.gpio_oeb[OUT_BASE + j] = ~en_q;
    end
  end

  assign io.pb_level = level_q;
  assign io.pb_rise  = rise_q;
  assign io.core_en  = en_q;

endmodule

// File: tb/tb_tmnt_io_frontend.sv
// Directed bench for tmnt_io_frontend with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Autorepeat expectations follow TMNT_AUTOREPEAT_EN when the bench is built with it.
module tb_tmnt_io_frontend;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  tmnt_io_frontend_if #(.NUM_GPIO(34), .IN_WIDTH(15), .OUT_WIDTH(3)) io ();

  tmnt_io_frontend #(
    .NUM_GPIO(34), .IN_WIDTH(15), .IN_BASE(0), .OUT_WIDTH(3), .OUT_BASE(15),
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(64), .REPEAT_PERIOD(16)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [33:0] OEB_SEL = ~(34'h7 << 15);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    io.ncs      = 1'b0;
    io.gpio_in  = '1;
    io.core_out = 3'b111;
    n_rst       = 1'b0;
    step(2);
    checks++;
    if (io.pb_level !== 15'h0) begin errors++; $display("FAIL reset_level: got %h expected %h", io.pb_level, 15'h0); end
    checks++;
    if (io.pb_rise !== 15'h0) begin errors++; $display("FAIL reset_rise: got %h expected %h", io.pb_rise, 15'h0); end
    checks++;
    if (io.gpio_oeb !== 34'h3_ffff_ffff) begin errors++; $display("FAIL reset_oeb: got %h expected %h", io.gpio_oeb, 34'h3_ffff_ffff); end
    checks++;
    if (io.gpio_out !== 34'h0) begin errors++; $display("FAIL reset_out: got %h expected %h", io.gpio_out, 34'h0); end
    checks++;
    if (io.core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b expected 0", io.core_en); end
    n_rst       = 1'b1;
    io.gpio_in  = '0;
    io.core_out = 3'b000;
    step(1);
    checks++;
    if (io.core_en !== 1'b1) begin errors++; $display("FAIL reset_release_core_en: got %b expected 1", io.core_en); end
    step(8);
  endtask

  task automatic test_press;
    io.gpio_in[3] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      checks++;
      if (io.pb_level[3] !== (k >= 6)) begin errors++; $display("FAIL press_level k=%0d: got %b expected %b", k, io.pb_level[3], (k >= 6)); end
      checks++;
      if (io.pb_rise !== ((k == 6) ? 15'h0008 : 15'h0)) begin errors++; $display("FAIL press_rise k=%0d: got %h expected %h", k, io.pb_rise, ((k == 6) ? 15'h0008 : 15'h0)); end
    end
    io.gpio_in[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      checks++;
      if (io.pb_rise !== 15'h0) begin errors++; $display("FAIL release_rise k=%0d: got %h expected 0", k, io.pb_rise); end
      checks++;
      if (io.pb_level[3] !== (k < 6)) begin errors++; $display("FAIL release_level k=%0d: got %b expected %b", k, io.pb_level[3], (k < 6)); end
    end
  endtask

  task automatic test_glitch;
    int pulses6;
    io.gpio_in[5] = 1'b1;
    step(3);
    io.gpio_in[5] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (io.pb_level[5] !== 1'b0 || io.pb_rise[5] !== 1'b0) begin errors++; $display("FAIL glitch3 k=%0d: got level %b rise %b expected 0 0", k, io.pb_level[5], io.pb_rise[5]); end
      step(1);
    end
    pulses6 = 0;
    io.gpio_in[6] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      if (k == 4) io.gpio_in[6] = 1'b0;
      if (io.pb_rise[6] === 1'b1) pulses6++;
      if (k == 6) begin
        checks++;
        if (io.pb_level[6] !== 1'b1) begin errors++; $display("FAIL glitch4_accept: got %b expected 1", io.pb_level[6]); end
      end
    end
    checks++;
    if (pulses6 != 1) begin errors++; $display("FAIL glitch4_pulses: got %0d expected 1", pulses6); end
    checks++;
    if (io.pb_level[6] !== 1'b0) begin errors++; $display("FAIL glitch4_release: got %b expected 0", io.pb_level[6]); end
  endtask

  task automatic test_simultaneous;
    io.gpio_in[7] = 1'b1;
    io.gpio_in[9] = 1'b1;
    step(6);
    checks++;
    if (io.pb_rise !== 15'h0280) begin errors++; $display("FAIL simul_rise: got %h expected %h", io.pb_rise, 15'h0280); end
    step(1);
    checks++;
    if (io.pb_rise !== 15'h0 || io.pb_level !== 15'h0280) begin errors++; $display("FAIL simul_after: got rise %h level %h expected 0 0280", io.pb_rise, io.pb_level); end
    io.gpio_in[7] = 1'b0;
    io.gpio_in[9] = 1'b0;
    step(8);
  endtask

  task automatic test_output;
    io.core_out = 3'b101;
    step(1);
    checks++;
    if (io.gpio_out !== (34'h5 << 15)) begin errors++; $display("FAIL out_101: got %h expected %h", io.gpio_out, (34'h5 << 15)); end
    checks++;
    if (io.gpio_oeb !== OEB_SEL) begin errors++; $display("FAIL out_oeb: got %h expected %h", io.gpio_oeb, OEB_SEL); end
    io.core_out = 3'b010;
    #1;
    checks++;
    if (io.gpio_out !== (34'h5 << 15)) begin errors++; $display("FAIL out_latency: got %h expected %h", io.gpio_out, (34'h5 << 15)); end
    step(1);
    checks++;
    if (io.gpio_out !== (34'h2 << 15)) begin errors++; $display("FAIL out_010: got %h expected %h", io.gpio_out, (34'h2 << 15)); end
  endtask

  task automatic test_deselect;
    int pulses;
    io.gpio_in[0] = 1'b1;
    step(8);
    checks++;
    if (io.pb_level[0] !== 1'b1) begin errors++; $display("FAIL desel_pre_level: got %b expected 1", io.pb_level[0]); end
    io.ncs = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      checks++;
      if (io.pb_level !== 15'h0 || io.pb_rise !== 15'h0 || io.gpio_oeb !== 34'h3_ffff_ffff || io.gpio_out !== 34'h0 || io.core_en !== 1'b0) begin
        errors++;
        $display("FAIL desel_state k=%0d: got level %h rise %h oeb %h out %h en %b expected 0 0 3ffffffff 0 0",
                 k, io.pb_level, io.pb_rise, io.gpio_oeb, io.gpio_out, io.core_en);
      end
    end
    io.ncs = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (io.pb_rise[0] === 1'b1) pulses++;
      if (k == 1) begin
        checks++;
        if (io.core_en !== 1'b1 || io.gpio_oeb !== OEB_SEL) begin errors++; $display("FAIL resel_en: got en %b oeb %h expected 1 %h", io.core_en, io.gpio_oeb, OEB_SEL); end
      end
      if (k == 6) begin
        checks++;
        if (io.pb_rise[0] !== 1'b1) begin errors++; $display("FAIL resel_rise_at6: got %b expected 1", io.pb_rise[0]); end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL resel_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_autorepeat;
    logic exp;
    io.gpio_in[1] = 1'b1;
    step(6);
    checks++;
    if (io.pb_rise[1] !== 1'b1 || io.pb_level[1] !== 1'b1) begin errors++; $display("FAIL rep_accept: got rise %b level %b expected 1 1", io.pb_rise[1], io.pb_level[1]); end
    for (int k = 1; k < 120; k++) begin
      step(1);
`ifdef TMNT_AUTOREPEAT_EN
      exp = (k == 64) || (k == 80) || (k == 96) || (k == 112);
`else
      exp = 1'b0;
`endif
      checks++;
      if (io.pb_rise[1] !== exp) begin errors++; $display("FAIL rep_rise k=%0d: got %b expected %b", k, io.pb_rise[1], exp); end
    end
    io.gpio_in = '0;
    step(8);
    checks++;
    if (io.pb_level !== 15'h0 || io.pb_rise !== 15'h0) begin errors++; $display("FAIL rep_release: got level %h rise %h expected 0 0", io.pb_level, io.pb_rise); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_press();
    test_glitch();
    test_simultaneous();
    test_output();
    test_deselect();
    test_autorepeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
